// File: rtl/sync_fifo_v2_pkg.sv
// Shared constants and status bundle for the sync_fifo_v2 slice.
// Build option: SYNC_FIFO_FWFT_EN selects show-ahead read data.
package sync_fifo_pkg;

    localparam int FIFO_DEF_ADDR_W = 2;
    localparam int FIFO_DEF_DATA_W = 8;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_v2_if.sv
// Producer/consumer bundle for sync_fifo_v2.
// The FIFO takes the slave side; its user takes master.
interface sync_fifo_v2_if
    import sync_fifo_pkg::*;
#(
    parameter type DATA_T = logic [FIFO_DEF_DATA_W-1:0],
    parameter int  ADDR_W = FIFO_DEF_ADDR_W
);

    logic            wr_en;
    DATA_T           wr_data;
    logic            rd_en;
    DATA_T           rd_data;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic            almost_empty;
    logic            almost_full;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, empty, full,
        input  almost_empty, almost_full, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, empty, full,
        output almost_empty, almost_full, count,
        output overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_v2_ptr_ctrl.sv
// Pointers, accept logic, flags, count and sticky errors.
// Wrap-bit pointers distinguish full from empty.
module fifo_ptr_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_W    = FIFO_DEF_ADDR_W,
    parameter int AFULL_TH  = (1 << ADDR_W) - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_acc,
    output logic              rd_acc,
    output logic [ADDR_W:0]   count,
    output fifo_status_t      status
);

    localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AEMPTY_TH);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            empty;
    logic            full;
    logic            ovf;
    logic            udf;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0])
                && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign count = wr_ptr - rd_ptr;

    // Requests in a reset cycle must not touch memory or pointers.
    assign wr_acc  = wr_en && !full && !reset;
    assign rd_acc  = rd_en && !empty && !reset;
    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    assign status.empty        = empty;
    assign status.full         = full;
    assign status.almost_empty = (count <= AE);
    assign status.almost_full  = (count >= AF);
    assign status.overflow     = ovf;
    assign status.underflow    = udf;

    // Advance pointers on accepted ops; latch dropped-request errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full)  ovf <= 1'b1;
            if (rd_en && empty) udf <= 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_v2.sv
// Synchronous single-clock FIFO: storage plus read-data path.
// Build option: SYNC_FIFO_FWFT_EN selects show-ahead read data.
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter type DATA_T    = logic [FIFO_DEF_DATA_W-1:0],
    parameter int  ADDR_W    = FIFO_DEF_ADDR_W,
    parameter int  AFULL_TH  = (1 << ADDR_W) - 1,
    parameter int  AEMPTY_TH = 1
) (
    input logic           clk,
    input logic           reset,
    sync_fifo_v2_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    DATA_T             mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_acc;
    logic              rd_acc;
    fifo_status_t      status;

    fifo_ptr_ctrl #(
        .ADDR_W    (ADDR_W),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_ptr (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.wr_en),
        .rd_en   (bus.rd_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .wr_acc  (wr_acc),
        .rd_acc  (rd_acc),
        .count   (bus.count),
        .status  (status)
    );

    assign bus.empty        = status.empty;
    assign bus.full         = status.full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.overflow     = status.overflow;
    assign bus.underflow    = status.underflow;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_addr] <= bus.wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_rd_acc;

    assign unused_rd_acc = rd_acc;
    assign bus.rd_data   = mem[rd_addr];
    assign bus.rd_valid  = !status.empty;
`else
    DATA_T rd_q;
    logic  rv_q;

    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = rv_q;

    // Capture the head on an accepted read; data holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= rd_acc;
            if (rd_acc) rd_q <= mem[rd_addr];
        end
    end
`endif

endmodule
